// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RV32I subset datapath (lw/sw/R/I/branch/jal/jalr/lui).
// ImmSrc decodes from op in every state; the write enables are forced low while reset is held.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic       Illegal
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
        EXECI, ALUWB, BRANCH, JAL, JALRADR, JALRJ, LUI
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t     state_q, state_d;
    logic       pc_write_c, mem_write_c, ir_write_c, reg_write_c, illegal_c;
    logic [2:0] alu_exec_c;

    // NOTE: state register uses non-blocking assignment; reset is asynchronous and lands in FETCH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= FETCH;
        else      state_q <= state_d;
    end

    // funct7[5] selects sub only for register-register ops; addi with that bit set is still add.
    always_comb begin
        unique case (funct3)
            3'b000:  alu_exec_c = (state_q == EXECR && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_exec_c = ALU_AND;
            3'b110:  alu_exec_c = ALU_OR;
            3'b100:  alu_exec_c = ALU_XOR;
            3'b010:  alu_exec_c = ALU_SLT;
            default: alu_exec_c = ALU_ADD;
        endcase
    end

    always_comb begin
        unique case (op)
            OP_LW, OP_I, OP_JALR: ImmSrc = 3'b000;
            OP_SW:                ImmSrc = 3'b001;
            OP_BR:                ImmSrc = 3'b010;
            OP_JAL:               ImmSrc = 3'b011;
            OP_LUI:               ImmSrc = 3'b100;
            default:              ImmSrc = 3'b000;
        endcase
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        pc_write_c  = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        illegal_c   = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUControl  = ALU_ADD;
        unique case (state_q)
            FETCH: begin
                ir_write_c = 1'b1;
                pc_write_c = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                state_d    = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                unique case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_BR:        state_d = BRANCH;
                    OP_JAL:       state_d = JAL;
                    OP_JALR:      state_d = JALRADR;
                    OP_LUI:       state_d = LUI;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_c = 1'b1;
                state_d     = FETCH;
            end
            MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_c = 1'b1;
                state_d     = FETCH;
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_exec_c;
                state_d    = ALUWB;
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_exec_c;
                state_d    = ALUWB;
            end
            ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                pc_write_c = (funct3 == 3'b000) ? Zero : (funct3 == 3'b001) ? ~Zero : 1'b0;
                state_d    = FETCH;
            end
            JAL, JALRJ: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_write_c = 1'b1;
                state_d    = ALUWB;
            end
            JALRADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = JALRJ;
            end
            LUI: begin
                ResultSrc   = 2'b11;
                reg_write_c = 1'b1;
                state_d     = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Reset parks the FSM in FETCH, which would otherwise assert PCWrite/IRWrite; mask them.
    assign PCWrite  = rst & pc_write_c;
    assign MemWrite = rst & mem_write_c;
    assign IRWrite  = rst & ir_write_c;
    assign RegWrite = rst & reg_write_c;
    assign Illegal  = rst & illegal_c;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: table vectors, random instructions against a step-list model,
// and hand sequences for reset held at power-up and asserted mid-instruction.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .Zero(Zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .Illegal(Illegal)
    );

    typedef struct packed {
        logic       pcw, adr, mw, irw;
        logic [1:0] rs, sa, sb;
        logic [2:0] alu, imm;
        logic       rw, ill;
    } ctl_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       z;
        int         lat;
        logic [7:0] pcw_m, rw_m, mw_m, ill_m;
        logic [2:0] alu3;
        logic [1:0] rs_rw;
    } vec_t;

    vec_t vecs[$];
    ctl_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ctl_t observed();
        ctl_t c;
        c = '{pcw: PCWrite, adr: AdrSrc, mw: MemWrite, irw: IRWrite, rs: ResultSrc,
              sa: ALUSrcA, sb: ALUSrcB, alu: ALUControl, imm: ImmSrc, rw: RegWrite, ill: Illegal};
        return c;
    endfunction

    // Reference model: each instruction class is a list of per-cycle control records.
    function automatic logic [2:0] imm_of(input logic [6:0] o);
        if (o == 7'b0000011 || o == 7'b0010011 || o == 7'b1100111) return 3'd0;
        if (o == 7'b0100011) return 3'd1;
        if (o == 7'b1100011) return 3'd2;
        if (o == 7'b1101111) return 3'd3;
        if (o == 7'b0110111) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic [6:0] f7, input bit is_r);
        if (f3 == 3'b000) return (is_r && f7[5]) ? 3'd1 : 3'd0;
        if (f3 == 3'b111) return 3'd2;
        if (f3 == 3'b110) return 3'd3;
        if (f3 == 3'b100) return 3'd4;
        if (f3 == 3'b010) return 3'd5;
        return 3'd0;
    endfunction

    task automatic model_push(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7, input logic z);
        ctl_t b, c, wb, jmp;
        b = '0;
        b.imm = imm_of(o);
        wb = b;  wb.rw = 1'b1;
        jmp = b; jmp.sa = 2'd1; jmp.sb = 2'd2; jmp.pcw = 1'b1;
        c = b; c.irw = 1'b1; c.pcw = 1'b1; c.sb = 2'd2; c.rs = 2'd2;
        exp_q.push_back(c);
        c = b; c.sa = 2'd1; c.sb = 2'd1;
        c.ill = !(o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111});
        exp_q.push_back(c);
        case (o)
            7'b0000011, 7'b0100011: begin
                c = b; c.sa = 2'd2; c.sb = 2'd1; exp_q.push_back(c);
                if (o == 7'b0000011) begin
                    c = b; c.adr = 1'b1; exp_q.push_back(c);
                    c = wb; c.rs = 2'd1; exp_q.push_back(c);
                end else begin
                    c = b; c.adr = 1'b1; c.mw = 1'b1; exp_q.push_back(c);
                end
            end
            7'b0110011: begin
                c = b; c.sa = 2'd2; c.alu = alu_of(f3, f7, 1'b1); exp_q.push_back(c);
                exp_q.push_back(wb);
            end
            7'b0010011: begin
                c = b; c.sa = 2'd2; c.sb = 2'd1; c.alu = alu_of(f3, f7, 1'b0); exp_q.push_back(c);
                exp_q.push_back(wb);
            end
            7'b1100011: begin
                c = b; c.sa = 2'd2; c.alu = 3'd1;
                c.pcw = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : 1'b0;
                exp_q.push_back(c);
            end
            7'b1101111: begin
                exp_q.push_back(jmp);
                exp_q.push_back(wb);
            end
            7'b1100111: begin
                c = b; c.sa = 2'd2; c.sb = 2'd1; exp_q.push_back(c);
                exp_q.push_back(jmp);
                exp_q.push_back(wb);
            end
            7'b0110111: begin
                c = wb; c.rs = 2'd3; exp_q.push_back(c);
            end
            default: ;
        endcase
    endtask

    // Entered and left at posedge+1 with the DUT in FETCH.
    task automatic run_vec(input vec_t v);
        logic [7:0] pcw_m, rw_m, mw_m, ill_m, irw_m;
        logic [2:0] alu3;
        logic [1:0] rs_rw;
        pcw_m = '0; rw_m = '0; mw_m = '0; ill_m = '0; irw_m = '0; alu3 = '0; rs_rw = '0;
        op = v.op; funct3 = v.f3; funct7 = v.f7; Zero = v.z;
        for (int c = 1; c <= v.lat; c++) begin
            @(negedge clk);
            pcw_m[c-1] = PCWrite;
            rw_m[c-1]  = RegWrite;
            mw_m[c-1]  = MemWrite;
            ill_m[c-1] = Illegal;
            irw_m[c-1] = IRWrite;
            if (c == 3) alu3 = ALUControl;
            if (RegWrite) rs_rw = ResultSrc;
            @(posedge clk);
            #1;
        end
        check({v.name, " back_in_fetch"}, {IRWrite, ALUSrcB}, {1'b1, 2'b10});
        check({v.name, " irwrite_cycles"}, irw_m, 8'h01);
        check({v.name, " pcwrite_cycles"}, pcw_m, v.pcw_m);
        check({v.name, " regwrite_cycles"}, rw_m, v.rw_m);
        check({v.name, " memwrite_cycles"}, mw_m, v.mw_m);
        check({v.name, " illegal_cycles"}, ill_m, v.ill_m);
        check({v.name, " alucontrol_c3"}, alu3, v.alu3);
        check({v.name, " resultsrc_wb"}, rs_rw, v.rs_rw);
    endtask

    task automatic run_random(input int n);
        logic [6:0] ops[8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                               7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
        logic [6:0] o;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       z;
        ctl_t       e;
        for (int i = 0; i < n; i++) begin
            o  = ($urandom_range(0, 9) < 9) ? ops[$urandom_range(0, 7)] : 7'($urandom);
            f3 = 3'($urandom);
            f7 = 7'($urandom);
            z  = 1'($urandom);
            exp_q.delete();
            model_push(o, f3, f7, z);
            op = o; funct3 = f3; funct7 = f7; Zero = z;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                @(negedge clk);
                check($sformatf("rand%0d op=%b f3=%b", i, o, f3), observed(), e);
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        vecs.push_back('{"add",    7'b0110011, 3'b000, 7'b0000000, 1'b0, 4, 8'h01, 8'h08, 8'h00, 8'h00, 3'b000, 2'b00});
        vecs.push_back('{"sub",    7'b0110011, 3'b000, 7'b0100000, 1'b0, 4, 8'h01, 8'h08, 8'h00, 8'h00, 3'b001, 2'b00});
        vecs.push_back('{"and",    7'b0110011, 3'b111, 7'b0000000, 1'b0, 4, 8'h01, 8'h08, 8'h00, 8'h00, 3'b010, 2'b00});
        vecs.push_back('{"or",     7'b0110011, 3'b110, 7'b0000000, 1'b1, 4, 8'h01, 8'h08, 8'h00, 8'h00, 3'b011, 2'b00});
        vecs.push_back('{"xor",    7'b0110011, 3'b100, 7'b0000000, 1'b0, 4, 8'h01, 8'h08, 8'h00, 8'h00, 3'b100, 2'b00});
        vecs.push_back('{"slt",    7'b0110011, 3'b010, 7'b0000000, 1'b0, 4, 8'h01, 8'h08, 8'h00, 8'h00, 3'b101, 2'b00});
        vecs.push_back('{"r_f3_1", 7'b0110011, 3'b001, 7'b0100000, 1'b0, 4, 8'h01, 8'h08, 8'h00, 8'h00, 3'b000, 2'b00});
        vecs.push_back('{"addi_f7",7'b0010011, 3'b000, 7'b0100000, 1'b0, 4, 8'h01, 8'h08, 8'h00, 8'h00, 3'b000, 2'b00});
        vecs.push_back('{"xori",   7'b0010011, 3'b100, 7'b0000000, 1'b0, 4, 8'h01, 8'h08, 8'h00, 8'h00, 3'b100, 2'b00});
        vecs.push_back('{"lw",     7'b0000011, 3'b010, 7'b0000000, 1'b0, 5, 8'h01, 8'h10, 8'h00, 8'h00, 3'b000, 2'b01});
        vecs.push_back('{"sw",     7'b0100011, 3'b010, 7'b0000000, 1'b0, 4, 8'h01, 8'h00, 8'h08, 8'h00, 3'b000, 2'b00});
        vecs.push_back('{"beq_z1", 7'b1100011, 3'b000, 7'b0000000, 1'b1, 3, 8'h05, 8'h00, 8'h00, 8'h00, 3'b001, 2'b00});
        vecs.push_back('{"beq_z0", 7'b1100011, 3'b000, 7'b0000000, 1'b0, 3, 8'h01, 8'h00, 8'h00, 8'h00, 3'b001, 2'b00});
        vecs.push_back('{"bne_z0", 7'b1100011, 3'b001, 7'b0000000, 1'b0, 3, 8'h05, 8'h00, 8'h00, 8'h00, 3'b001, 2'b00});
        vecs.push_back('{"bne_z1", 7'b1100011, 3'b001, 7'b0000000, 1'b1, 3, 8'h01, 8'h00, 8'h00, 8'h00, 3'b001, 2'b00});
        vecs.push_back('{"blt_z1", 7'b1100011, 3'b100, 7'b0000000, 1'b1, 3, 8'h01, 8'h00, 8'h00, 8'h00, 3'b001, 2'b00});
        vecs.push_back('{"jal",    7'b1101111, 3'b000, 7'b0000000, 1'b0, 4, 8'h05, 8'h08, 8'h00, 8'h00, 3'b000, 2'b00});
        vecs.push_back('{"jalr",   7'b1100111, 3'b000, 7'b0000000, 1'b0, 5, 8'h09, 8'h10, 8'h00, 8'h00, 3'b000, 2'b00});
        vecs.push_back('{"lui",    7'b0110111, 3'b000, 7'b0000000, 1'b0, 3, 8'h01, 8'h04, 8'h00, 8'h00, 3'b000, 2'b11});
        vecs.push_back('{"illegal",7'b1111111, 3'b000, 7'b0000000, 1'b0, 2, 8'h01, 8'h00, 8'h00, 8'h02, 3'b000, 2'b00});

        rst = 1'b0; op = 7'b1111111; funct3 = '0; funct7 = '0; Zero = 1'b0;
        #3;
        check("reset_enables_low", {PCWrite, MemWrite, RegWrite, IRWrite, Illegal}, 5'b0);
        check("reset_state_fetch", ALUSrcB, 2'b10);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_held_over_edges", {PCWrite, MemWrite, RegWrite, IRWrite, Illegal}, 5'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("release_in_fetch", {IRWrite, PCWrite, ALUSrcB}, {1'b1, 1'b1, 2'b10});

        foreach (vecs[i]) run_vec(vecs[i]);
        run_random(150);

        // Reset asserted mid-store must drop MemWrite with no clock edge.
        op = 7'b0100011; funct3 = 3'b010; funct7 = '0; Zero = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("midreset_memwrite_before", MemWrite, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("midreset_memwrite_async", MemWrite, 1'b0);
        check("midreset_enables_low", {PCWrite, RegWrite, IRWrite, Illegal}, 4'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midreset_release_fetch", {IRWrite, ALUSrcA, ALUSrcB}, {1'b1, 2'b00, 2'b10});
        @(posedge clk);
        #1;
        check("midreset_then_decode", {IRWrite, ALUSrcA, ALUSrcB}, {1'b0, 2'b01, 2'b01});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
